// File: rtl/nsa_pkg.sv
// -----------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for the nibble-serial adder controller and its 4-bit
// ripple-carry datapath.
//   NIB_W   : width of one adder slice (one nibble).
//   state_e : controller state encoding. The code 2'd3 is unused and
//             recovers to IDLE.
// -----------------------------------------------------------------------------
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_adder_4_bit.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_4_bit
// Purely combinational nibble adder built from a chain of full adders.
// Ports:
//   a, b  [NIB_W-1:0] in  : addend nibbles
//   cin               in  : carry into bit 0
//   sum   [NIB_W-1:0] out : nibble sum
//   cout              out : carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_carry_adder_4_bit
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit addition one nibble per clock, least-significant nibble
// first, through a single 4-bit ripple-carry adder. Operands are latched on
// the accepting edge; the carry is registered between nibbles and the result
// is assembled into the sum register.
//
// Parameters:
//   WIDTH : operand/result width, a multiple of 4 and at least 4.
// Ports:
//   clk   in  : rising-edge clock
//   rst   in  : synchronous active-high reset
//   start in  : request, accepted only while busy=0
//   a, b  in  : operands, sampled on the accepting edge
//   cin   in  : carry-in, sampled on the accepting edge
//   busy  out : high in RUN and DONE
//   done  out : one-cycle pulse, sum/cout valid while high
//   sum   out : result register, held until the next accepted start
//   cout  out : final carry-out register
//   ovf   out : signed overflow flag (only when NSA_OVERFLOW_EN is defined)
//
// Build option: define NSA_OVERFLOW_EN to add the ovf port and its logic.
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_op_q, a_op_d;
  logic [WIDTH-1:0] b_op_q, b_op_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0] a_nib, b_nib, nib_sum;
  logic             nib_cout;

  // Select operand nibble idx; compare-per-slice keeps index widths exact.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_op_q[NIB_W*i +: NIB_W];
        b_nib = b_op_q[NIB_W*i +: NIB_W];
      end
    end
  end

  ripple_carry_adder_4_bit u_rca (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_op_d  = a;
          b_op_d  = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end

      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[NIB_W*i +: NIB_W] = nib_sum;
          end
        end
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef NSA_OVERFLOW_EN
          // The top bit of the final nibble is the result MSB.
          ovf_d   = (a_op_q[WIDTH-1] == b_op_q[WIDTH-1]) &&
                    (nib_sum[NIB_W-1] != a_op_q[WIDTH-1]);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule
